// File: rtl/game_flow_ctrl.sv
// Game-flow state machine: title -> play -> dying/clear -> game over, with lives and screen select.
// Optional DEBOUNCE_EN macro adds a 2-flop synchroniser and per-bit debounce on movement.
module game_flow_ctrl #(
    parameter int LIVES_INIT      = 3,
    parameter int DYING_FRAMES    = 120,
    parameter int CLEAR_FRAMES    = 180,
    parameter int DEBOUNCE_CYCLES = 250000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       frame_tick,
    input  logic [5:0] movement,
    input  logic       mario_dead,
    input  logic       level_clear,
    input  logic       End_end,
    output logic       over,
    output logic       playing,
    output logic       game_reset,
    output logic [2:0] lives,
    output logic [1:0] screen_sel
);

    localparam int NUM_LANES = 6;

    typedef enum logic [2:0] {
        TITLE = 3'd0,
        PLAY  = 3'd1,
        DYING = 3'd2,
        CLEAR = 3'd3,
        OVER  = 3'd4
    } state_t;

    localparam logic [9:0] DYING_LAST = 10'(DYING_FRAMES - 1);
    localparam logic [9:0] CLEAR_LAST = 10'(CLEAR_FRAMES - 1);

    logic [NUM_LANES-1:0] mv_cond;

`ifdef DEBOUNCE_EN
    localparam int DBW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [DBW-1:0] DB_LAST = DBW'(DEBOUNCE_CYCLES - 1);

    logic [NUM_LANES-1:0]          sync1, sync2;
    logic [NUM_LANES-1:0][DBW-1:0] db_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= movement;
            sync2 <= sync1;
        end
    end

    // Each lane flips only after DEBOUNCE_CYCLES consecutive cycles of disagreement.
    for (genvar i = 0; i < NUM_LANES; i++) begin : g_db
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                db_cnt[i]  <= '0;
                mv_cond[i] <= 1'b0;
            end else if (sync2[i] == mv_cond[i]) begin
                db_cnt[i]  <= '0;
            end else if (db_cnt[i] == DB_LAST) begin
                db_cnt[i]  <= '0;
                mv_cond[i] <= sync2[i];
            end else begin
                db_cnt[i]  <= db_cnt[i] + 1'b1;
            end
        end
    end
`else
    logic unused_param;
    assign mv_cond      = movement;
    assign unused_param = DEBOUNCE_CYCLES[0];
`endif

    logic unused_bits;
    assign unused_bits = ^mv_cond[3:0];

    state_t     state, state_n;
    logic [9:0] cnt, cnt_n;
    logic [2:0] lives_n;
    logic       start_prev, start_btn, start_rise;
    logic       gr_n, over_n, playing_n;
    logic [1:0] sel_n;

    assign start_btn  = mv_cond[4] | mv_cond[5];
    assign start_rise = start_btn & ~start_prev;

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        lives_n = lives;
        gr_n    = 1'b0;
        case (state)
            TITLE: begin
                if (start_rise) begin
                    state_n = PLAY;
                    lives_n = 3'(LIVES_INIT);
                    gr_n    = 1'b1;
                end
            end
            PLAY: begin
                if (mario_dead) begin
                    state_n = DYING;
                    lives_n = (lives == 3'd0) ? 3'd0 : lives - 3'd1;
                end else if (level_clear) begin
                    state_n = CLEAR;
                end
            end
            DYING: begin
                if (frame_tick) begin
                    if (cnt == DYING_LAST) begin
                        if (lives == 3'd0) begin
                            state_n = OVER;
                        end else begin
                            state_n = PLAY;
                            gr_n    = 1'b1;
                        end
                    end else begin
                        cnt_n = cnt + 10'd1;
                    end
                end
            end
            CLEAR: begin
                if (frame_tick) begin
                    if (cnt == CLEAR_LAST) state_n = TITLE;
                    else                   cnt_n   = cnt + 10'd1;
                end
            end
            OVER: begin
                if (End_end) state_n = TITLE;
            end
            default: state_n = TITLE;
        endcase
        // Every state entry starts the frame counter from zero.
        if (state_n != state) cnt_n = '0;
    end

    // Outputs are decoded from the next state so they register with it.
    always_comb begin
        over_n    = (state_n == OVER);
        playing_n = (state_n == PLAY);
        case (state_n)
            TITLE:       sel_n = 2'd0;
            PLAY, DYING: sel_n = 2'd1;
            OVER:        sel_n = 2'd2;
            CLEAR:       sel_n = 2'd3;
            default:     sel_n = 2'd0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= TITLE;
            cnt        <= '0;
            start_prev <= 1'b0;
            lives      <= 3'(LIVES_INIT);
            game_reset <= 1'b0;
            over       <= 1'b0;
            playing    <= 1'b0;
            screen_sel <= 2'd0;
        end else begin
            state      <= state_n;
            cnt        <= cnt_n;
            start_prev <= start_btn;
            lives      <= lives_n;
            game_reset <= gr_n;
            over       <= over_n;
            playing    <= playing_n;
            screen_sel <= sel_n;
        end
    end

endmodule

// File: tb/tb_game_flow_ctrl.sv
// Self-checking bench for game_flow_ctrl: directed test-plan steps plus random traffic,
// all checked every cycle against a mode/frames-remaining reference model.
module tb_game_flow_ctrl;

    localparam int LIVES_INIT   = 3;
    localparam int DYING_FRAMES = 120;
    localparam int CLEAR_FRAMES = 180;
`ifdef DEBOUNCE_EN
    localparam int DBC = 8;
`else
    localparam int DBC = 250000;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       frame_tick, mario_dead, level_clear, End_end;
    logic [5:0] movement;
    logic       over, playing, game_reset;
    logic [2:0] lives;
    logic [1:0] screen_sel;

    int n_assert = 0;
    int n_fail   = 0;

    game_flow_ctrl #(
        .LIVES_INIT(LIVES_INIT), .DYING_FRAMES(DYING_FRAMES),
        .CLEAR_FRAMES(CLEAR_FRAMES), .DEBOUNCE_CYCLES(DBC)
    ) dut (
        .clk(clk), .rst(rst), .frame_tick(frame_tick), .movement(movement),
        .mario_dead(mario_dead), .level_clear(level_clear), .End_end(End_end),
        .over(over), .playing(playing), .game_reset(game_reset),
        .lives(lives), .screen_sel(screen_sel)
    );

    always #5 clk = ~clk;

    // Reference model: named mode plus a count of frames still to wait.
    string m_mode;
    int    m_left;
    bit    m_prev;
    int    m_lives;
    bit    m_gr;
`ifdef DEBOUNCE_EN
    logic [5:0] m_s1, m_s2, m_db;
    logic [5:0] m_hist[$];
`endif

    task automatic model_reset();
        m_mode  = "title";
        m_left  = 0;
        m_prev  = 0;
        m_lives = LIVES_INIT;
        m_gr    = 0;
`ifdef DEBOUNCE_EN
        m_s1 = '0; m_s2 = '0; m_db = '0;
        m_hist.delete();
`endif
    endtask

    task automatic model_step();
        logic [5:0] cv;
        bit btn, rise;
`ifdef DEBOUNCE_EN
        cv = m_db;
`else
        cv = movement;
`endif
        btn    = cv[4] | cv[5];
        rise   = btn && !m_prev;
        m_prev = btn;
        m_gr   = 0;
        case (m_mode)
            "title": if (rise) begin m_mode = "play"; m_lives = LIVES_INIT; m_gr = 1; end
            "play": begin
                if (mario_dead) begin
                    m_lives = (m_lives > 0) ? m_lives - 1 : 0;
                    m_mode  = "dying";
                    m_left  = DYING_FRAMES;
                end else if (level_clear) begin
                    m_mode = "clear";
                    m_left = CLEAR_FRAMES;
                end
            end
            "dying": if (frame_tick) begin
                m_left--;
                if (m_left == 0) begin
                    if (m_lives == 0) m_mode = "over";
                    else begin m_mode = "play"; m_gr = 1; end
                end
            end
            "clear": if (frame_tick) begin
                m_left--;
                if (m_left == 0) m_mode = "title";
            end
            "over": if (End_end) m_mode = "title";
            default: m_mode = "title";
        endcase
`ifdef DEBOUNCE_EN
        m_hist.push_back(m_s2);
        if (m_hist.size() > DBC) void'(m_hist.pop_front());
        if (m_hist.size() == DBC) begin
            for (int b = 0; b < 6; b++) begin
                bit same = 1;
                foreach (m_hist[k]) if (m_hist[k][b] != m_hist[0][b]) same = 0;
                if (same) m_db[b] = m_hist[0][b];
            end
        end
        m_s2 = m_s1;
        m_s1 = movement;
`endif
    endtask

    function automatic logic [1:0] exp_sel();
        case (m_mode)
            "play", "dying": return 2'd1;
            "over":          return 2'd2;
            "clear":         return 2'd3;
            default:         return 2'd0;
        endcase
    endfunction

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("over",       32'(over),       32'(m_mode == "over"));
        chk("playing",    32'(playing),    32'(m_mode == "play"));
        chk("game_reset", 32'(game_reset), 32'(m_gr));
        chk("lives",      32'(lives),      32'(m_lives));
        chk("screen_sel", 32'(screen_sel), 32'(exp_sel()));
    endtask

    task automatic cyc();
        @(posedge clk);
        model_step();
        #1;
        check_all();
    endtask

    task automatic cycles(int n);
        repeat (n) cyc();
    endtask

    task automatic tick_frames(int n);
        repeat (n) begin
            frame_tick = 1'b1; cyc();
            frame_tick = 1'b0; cyc();
        end
    endtask

    task automatic pulse_dead();
        mario_dead = 1'b1; cyc(); mario_dead = 1'b0;
    endtask

    task automatic press_start(int bit_idx, int hold);
        movement[bit_idx] = 1'b1; cycles(hold);
        movement[bit_idx] = 1'b0; cyc();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        model_reset();
        @(posedge clk); #1;
        check_all();
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; frame_tick = 0; mario_dead = 0; level_clear = 0; End_end = 0; movement = '0;
        model_reset();
        #2;
        check_all();
        do_reset();
        cycles(3);

        // Start: game_reset for one cycle, PLAY with full lives.
        press_start(4, 3);
        chk("lives_after_start", 32'(lives), 32'd3);
        cycles(2);

        // Three deaths: respawn twice, then game over.
        for (int d = 0; d < 3; d++) begin
            pulse_dead();
            tick_frames(DYING_FRAMES);
            cycles(2);
        end
        chk("over_after_3_deaths", 32'(over), 32'd1);
        pulse_dead(); pulse_dead();
        chk("lives_stay_zero", 32'(lives), 32'd0);

        // Held button through End_end must not restart; a fresh press does.
        movement[5] = 1'b1; cycles(3);
        End_end = 1'b1; cyc(); End_end = 1'b0;
        cycles(50);
        chk("held_stays_title", 32'(screen_sel), 32'd0);
        movement[5] = 1'b0; cycles(2);
        press_start(5, 2);
        chk("restart_play", 32'(playing), 32'd1);

        // Death beats level clear in the same cycle.
        mario_dead = 1'b1; level_clear = 1'b1; cyc();
        mario_dead = 1'b0; level_clear = 1'b0;
        chk("death_wins_sel", 32'(screen_sel), 32'd1);
        tick_frames(DYING_FRAMES);
        cycles(2);

        // Level clear: screen 3 for CLEAR_FRAMES ticks, then title.
        level_clear = 1'b1; cyc(); level_clear = 1'b0;
        mario_dead = 1'b1; cyc(); mario_dead = 1'b0;
        tick_frames(CLEAR_FRAMES);
        cycles(2);
        chk("clear_to_title", 32'(screen_sel), 32'd0);

        // Async reset in the middle of a death animation.
        press_start(4, 1);
        pulse_dead();
        tick_frames(60);
        #2 rst = 1'b1;
        #1;
        model_reset();
        check_all();
        chk("cnt_cleared", 32'(dut.cnt), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        cycles(2);
        press_start(4, 1);
        pulse_dead();
        tick_frames(DYING_FRAMES);
        cycles(2);

        // Random traffic.
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 7) == 0) movement = 6'($urandom_range(0, 63));
            frame_tick  = ($urandom_range(0, 1) == 0);
            mario_dead  = ($urandom_range(0, 59) == 0);
            level_clear = ($urandom_range(0, 79) == 0);
            End_end     = ($urandom_range(0, 9) == 0);
            cyc();
        end
        frame_tick = 0; mario_dead = 0; level_clear = 0; End_end = 0; movement = '0;
        cycles(2);

`ifdef DEBOUNCE_EN
        do_reset();
        cycles(DBC + 4);
        movement[4] = 1'b1; cycles(5);
        movement[4] = 1'b0; cycles(DBC + 10);
        chk("glitch_no_start", 32'(screen_sel), 32'd0);
        movement[4] = 1'b1; cycles(DBC + 6);
        chk("debounced_start", 32'(screen_sel), 32'd1);
        movement[4] = 1'b0; cycles(2);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/game_flow_ctrl.md
Name: game_flow_ctrl

Overview:
- Top-level game-flow state machine: title -> play -> dying/clear -> game over.
- Sits directly upstream of the game-over screen stage.
- Drives its `over` input and consumes its registered `End_end` restart strobe.
- Also tracks lives, pulses a world reset, and selects which screen source the VGA colour mux shows.

Parameters:
LIVES_INIT, 3, lives loaded at game start (1..7)
DYING_FRAMES, 120, frames spent in death animation before respawn/over (1..1023)
CLEAR_FRAMES, 180, frames spent on level-clear screen before returning to title (1..1023)
DEBOUNCE_CYCLES, 250000, stable-input cycles required per button (used only with DEBOUNCE_EN)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous reset, active-high
frame_tick  in  1  one-cycle pulse per video frame (start of vertical blank)
movement  in  6  player buttons; bits 4 and 5 are start/jump buttons
mario_dead  in  1  one-cycle pulse from collision logic
level_clear  in  1  one-cycle pulse when flag reached
End_end  in  1  restart strobe from game-over screen stage
over  out  1  high while in OVER state; feeds game-over screen stage
playing  out  1  high while in PLAY; enables physics/scroll
game_reset  out  1  one-cycle pulse: reload world/Mario position
lives  out  3  remaining lives
screen_sel  out  2  0 = title, 1 = game, 2 = game over, 3 = level clear

Behaviour:
- Reset: rst is asynchronous and active-high; asserting it at any time, including mid-count, forces the following:
  - state = TITLE, frame counter = 0, start-edge register = 0
  - over = 0, playing = 0, game_reset = 0, lives = LIVES_INIT, screen_sel = 0
- All outputs are registered and reflect the new state one cycle after the transition condition is sampled.
- start_btn = movement[4] | movement[5].
- start_rise = start_btn & ~start_prev, where start_prev is start_btn registered.
  - A held button never retriggers; it must be released first.
- States and encoding: TITLE = 0, PLAY = 1, DYING = 2, CLEAR = 3, OVER = 4.
- TITLE, screen_sel = 0:
  - On start_rise -> PLAY.
  - Same cycle: lives <= LIVES_INIT, game_reset pulses high for exactly 1 cycle.
- PLAY, screen_sel = 1, playing = 1:
  - mario_dead -> DYING, lives <= lives - 1, saturating at 0.
  - Otherwise level_clear -> CLEAR.
  - mario_dead and level_clear in the same cycle: death wins.
- DYING, screen_sel = 1, playing = 0:
  - Frame counter increments on each frame_tick.
  - When counter == DYING_FRAMES - 1 and frame_tick is high, clear counter, then:
    - lives == 0 -> OVER
    - else -> PLAY with a 1-cycle game_reset pulse.
- CLEAR, screen_sel = 3:
  - Counts CLEAR_FRAMES frame_ticks the same way as DYING, then -> TITLE.
- OVER, screen_sel = 2, over = 1:
  - End_end == 1 -> TITLE; over drops the next cycle.
  - The button press that produced End_end has already been consumed as an edge, so TITLE does not immediately restart.
- Ignored inputs:
  - mario_dead and level_clear are ignored outside PLAY.
  - End_end is ignored outside OVER.
  - start_rise is ignored outside TITLE.
- Counter is 10 bits and is cleared on every state entry.
- Illegal state encodings (5..7) return to TITLE on the next clock.

Optional Feature:
DEBOUNCE_EN:
- Defined:
  - movement passes through a 2-flop synchroniser.
  - Each bit is then a debounced copy that updates only after the synchronised value has been stable for DEBOUNCE_CYCLES consecutive cycles.
  - start_btn is derived from the debounced bits.
  - Adds latency of 2 + DEBOUNCE_CYCLES cycles.
- Undefined: movement is used raw (already synchronous from the keyboard decoder); zero added latency.

Test Plan:
- Reset, then press movement[4] for 3 cycles in TITLE -> game_reset high exactly 1 cycle, state PLAY, playing = 1, lives = 3, screen_sel = 1.
- PLAY with lives = 3, pulse mario_dead, supply 120 frame_ticks -> lives = 2, playing = 0 during DYING, then PLAY with a game_reset pulse after the 120th tick.
- Three deaths from LIVES_INIT = 3 -> after the 3rd dying period, over = 1, screen_sel = 2, lives = 0; extra mario_dead pulses leave lives at 0.
- In OVER, hold movement[5] and pulse End_end -> TITLE, over = 0; keep the button held 50 cycles -> stays TITLE; release and press again -> PLAY.
- mario_dead and level_clear asserted in the same PLAY cycle -> DYING, not CLEAR. Separately, level_clear then 180 ticks -> TITLE with screen_sel 3 during the wait.
- Assert rst mid-DYING at tick 60 -> all outputs at reset values immediately (asynchronously), counter = 0. With DEBOUNCE_EN and DEBOUNCE_CYCLES = 8, a 5-cycle glitch on movement[4] -> no transition.
